// File: rtl/pa_riscv.sv
// RV32I definitions shared by the decoder side and the instruction loader:
// opcode values, loader FSM states and instruction field positions.
package pa_riscv;

  typedef enum logic [6:0] {
    OPC_I = 7'b0000011,
    OPC_S = 7'b0100011,
    OPC_B = 7'b1100011
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int OPC_LSB    = 0;
  localparam int RD_LSB     = 7;
  localparam int F3_LSB     = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int IMM_I_LSB  = 20;
  localparam int IMM_HI_LSB = 25;

endpackage

// File: rtl/imm_pack.sv
// Packs decoded fields into an RV32I I/S/B word and flags whether the
// immediate is representable in that format. Purely combinational.
module imm_pack
  import pa_riscv::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_legal
);

  logic fits_12;
  logic fits_b;

  // A 12-bit field holds imm only if bits 31..11 are a pure sign extension.
  assign fits_12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign fits_b  = ((&i_imm[31:12]) | ~(|i_imm[31:12])) & ~i_imm[0];

  always_comb begin
    o_word  = '0;
    o_legal = 1'b0;
    o_word[OPC_LSB +: 7] = i_opcode;
    o_word[F3_LSB  +: 3] = i_funct3;
    o_word[RS1_LSB +: 5] = i_rs1;
    case (i_opcode)
      OPC_I: begin
        o_legal                  = fits_12;
        o_word[RD_LSB +: 5]      = i_rd;
        o_word[IMM_I_LSB +: 12]  = i_imm[11:0];
      end
      OPC_S: begin
        o_legal                  = fits_12;
        o_word[RD_LSB +: 5]      = i_imm[4:0];
        o_word[RS2_LSB +: 5]     = i_rs2;
        o_word[IMM_HI_LSB +: 7]  = i_imm[11:5];
      end
      OPC_B: begin
        o_legal                  = fits_b;
        o_word[RD_LSB]           = i_imm[11];
        o_word[RD_LSB+1 +: 4]    = i_imm[4:1];
        o_word[RS2_LSB +: 5]     = i_rs2;
        o_word[IMM_HI_LSB +: 6]  = i_imm[10:5];
        o_word[31]               = i_imm[12];
      end
      default: begin
        o_word = '0;
      end
    endcase
  end

endmodule

// File: rtl/imm_encode_loader.sv
// Encodes a stream of decoded instruction bundles and writes them into
// instruction memory from a programmed base address, aborting on bad input.
module imm_encode_loader
  import pa_riscv::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [31:0]      i_baseAddr,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [6:0]       i_opcode,
  input  logic [4:0]       i_rd,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [2:0]       i_funct3,
  input  logic [31:0]      i_imm,
  output logic             o_we,
  output logic [31:0]      o_addr,
  output logic [31:0]      o_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [CNT_W-1:0] o_errIndex
);

  state_e           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] index_q, index_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] err_index_q, err_index_d;

  logic [31:0] pack_word;
  logic        pack_legal;
  logic        unused_base_bits;

  // Base is always word aligned; the low address bits are dropped.
  assign unused_base_bits = ^i_baseAddr[1:0];

  imm_pack u_pack (
    .i_opcode (i_opcode),
    .i_rd     (i_rd),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .i_funct3 (i_funct3),
    .i_imm    (i_imm),
    .o_word   (pack_word),
    .o_legal  (pack_legal)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    done_d      = done_q;
    error_d     = error_q;
    err_index_d = err_index_q;
    case (state_q)
      ST_RUN: begin
        if (i_valid) begin
          if (pack_legal) begin
            we_d        = 1'b1;
            addr_d      = base_q + (32'(index_q) << 2);
            wdata_d     = pack_word;
            index_d     = index_q + CNT_W'(1);
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            state_d     = ST_ERR;
            error_d     = 1'b1;
            err_index_d = index_q;
          end
        end
      end
      default: begin
        if (i_start) begin
          base_d      = {i_baseAddr[31:2], 2'b00};
          remaining_d = i_count;
          index_d     = '0;
          error_d     = 1'b0;
          err_index_d = '0;
          done_d      = (i_count == '0);
          state_d     = (i_count == '0) ? ST_DONE : ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      remaining_q <= '0;
      index_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
    end
  end

  assign o_ready    = (state_q == ST_RUN);
  assign o_busy     = (state_q == ST_RUN);
  assign o_we       = we_q;
  assign o_addr     = addr_q;
  assign o_wdata    = wdata_q;
  assign o_done     = done_q;
  assign o_error    = error_q;
  assign o_errIndex = err_index_q;

endmodule

// File: tb/tb_imm_encode_loader.sv
// Directed and random checks for the instruction encoder/loader.
module tb_imm_encode_loader;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] count;
  logic             valid;
  logic             ready;
  logic [6:0]       opcode;
  logic [4:0]       rd, rs1, rs2;
  logic [2:0]       funct3;
  logic [31:0]      imm;
  logic             we;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic             busy, done, error;
  logic [CNT_W-1:0] err_index;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imm_encode_loader #(.CNT_W(CNT_W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_baseAddr (base_addr),
    .i_count    (count),
    .i_valid    (valid),
    .o_ready    (ready),
    .i_opcode   (opcode),
    .i_rd       (rd),
    .i_rs1      (rs1),
    .i_rs2      (rs2),
    .i_funct3   (funct3),
    .i_imm      (imm),
    .o_we       (we),
    .o_addr     (addr),
    .o_wdata    (wdata),
    .o_busy     (busy),
    .o_done     (done),
    .o_error    (error),
    .o_errIndex (err_index)
  );

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] b, input logic [CNT_W-1:0] c);
    start = 1'b1; base_addr = b; count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f, input logic [31:0] im);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f; imm = im; valid = 1'b1;
    tick();
    valid = 1'b0;
    $display("txn op=%b imm=0x%08h -> we=%0d addr=0x%08h wdata=0x%08h done=%0d err=%0d",
             op, im, we, addr, wdata, done, error);
  endtask

  // Reference extender: recovers the immediate from an encoded word.
  function automatic logic [31:0] ext_imm(input logic [31:0] w);
    case (w[6:0])
      7'b0000011: ext_imm = {{20{w[31]}}, w[31:20]};
      7'b0100011: ext_imm = {{20{w[31]}}, w[31:25], w[11:7]};
      7'b1100011: ext_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default:    ext_imm = 32'hDEAD_BEEF;
    endcase
  endfunction

  initial begin
    vecs[0]  = '{7'b0000011, 5'd5, 5'd2,  5'd0, 3'b010, 32'hFFFFFFFC, 1'b1, 32'hFFC12283};
    vecs[1]  = '{7'b0100011, 5'd0, 5'd2,  5'd6, 3'b010, 32'h00000008, 1'b1, 32'h00612423};
    vecs[2]  = '{7'b1100011, 5'd0, 5'd4,  5'd4, 3'b000, 32'hFFFFFFF8, 1'b1, 32'hFE420CE3};
    vecs[3]  = '{7'b0000011, 5'd1, 5'd0,  5'd0, 3'b000, 32'h000007FF, 1'b1, 32'h7FF00083};
    vecs[4]  = '{7'b0000011, 5'd0, 5'd31, 5'd0, 3'b111, 32'hFFFFF800, 1'b1, 32'h800FF003};
    vecs[5]  = '{7'b0100011, 5'd0, 5'd1,  5'd2, 3'b000, 32'hFFFFF800, 1'b1, 32'h80208023};
    vecs[6]  = '{7'b1100011, 5'd0, 5'd0,  5'd0, 3'b001, 32'h00000FFE, 1'b1, 32'h7E001FE3};
    vecs[7]  = '{7'b1100011, 5'd0, 5'd3,  5'd5, 3'b100, 32'hFFFFF000, 1'b1, 32'h8051C063};
    vecs[8]  = '{7'b0000011, 5'd1, 5'd1,  5'd0, 3'b000, 32'h00000800, 1'b0, 32'h0};
    vecs[9]  = '{7'b1100011, 5'd0, 5'd1,  5'd1, 3'b000, 32'h00000005, 1'b0, 32'h0};
    vecs[10] = '{7'b0110011, 5'd1, 5'd1,  5'd1, 3'b000, 32'h00000000, 1'b0, 32'h0};
    vecs[11] = '{7'b1100011, 5'd0, 5'd1,  5'd1, 3'b000, 32'h00001000, 1'b0, 32'h0};
    vecs[12] = '{7'b0100011, 5'd0, 5'd1,  5'd1, 3'b000, 32'h00000800, 1'b0, 32'h0};
    vecs[13] = '{7'b0000011, 5'd1, 5'd1,  5'd0, 3'b000, 32'hFFFFF7FF, 1'b0, 32'h0};

    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; valid = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; imm = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_outputs", {31'(err_index), we, addr, wdata, ready, busy, done, error}, '0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);

    // Single-bundle loads from the vector table.
    for (int i = 0; i < 14; i++) begin
      do_start(32'h0000_0100, 16'd1);
      chk("run_ready", {ready, busy}, 2'b11);
      send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].imm);
      if (vecs[i].legal) begin
        chk("vec_we", we, 1'b1);
        chk("vec_addr", addr, 32'h100);
        chk("vec_wdata", wdata, vecs[i].word);
        chk("vec_done", {done, error}, 2'b10);
        tick();
        chk("vec_we_one_cycle", {we, done}, 2'b01);
      end else begin
        chk("vec_err_we", we, 1'b0);
        chk("vec_err_flags", {error, done, ready, busy}, 4'b1000);
        chk("vec_err_index", err_index, 0);
      end
    end

    // Two-instruction load: S then B at consecutive addresses.
    do_start(32'h0000_0103, 16'd2);
    send(vecs[1].op, vecs[1].rd, vecs[1].rs1, vecs[1].rs2, vecs[1].f3, vecs[1].imm);
    chk("seq2_w0", {we, done}, 2'b10);
    chk("seq2_a0", addr, 32'h100);
    chk("seq2_d0", wdata, 32'h00612423);
    send(vecs[2].op, vecs[2].rd, vecs[2].rs1, vecs[2].rs2, vecs[2].f3, vecs[2].imm);
    chk("seq2_w1", {we, done}, 2'b11);
    chk("seq2_a1", addr, 32'h104);
    chk("seq2_d1", wdata, 32'hFE420CE3);

    // Illegal third bundle of four.
    do_start(32'h0000_0100, 16'd4);
    send(vecs[1].op, vecs[1].rd, vecs[1].rs1, vecs[1].rs2, vecs[1].f3, vecs[1].imm);
    send(vecs[2].op, vecs[2].rd, vecs[2].rs1, vecs[2].rs2, vecs[2].f3, vecs[2].imm);
    chk("err3_a1", addr, 32'h104);
    send(vecs[8].op, vecs[8].rd, vecs[8].rs1, vecs[8].rs2, vecs[8].f3, vecs[8].imm);
    chk("err3_flags", {we, error, done, ready}, 4'b0100);
    chk("err3_index", err_index, 2);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("err3_sticky", {we, error, ready}, 3'b010);

    // Zero-length load completes immediately.
    do_start(32'h0000_0400, 16'd0);
    chk("cnt0_done", {done, we, busy, error}, 4'b1000);
    tick();
    chk("cnt0_hold", {done, we}, 2'b10);

    // Start pulse during RUN is ignored.
    do_start(32'h0000_0200, 16'd3);
    send(7'b0000011, 5'd1, 5'd1, 5'd0, 3'b000, 32'h1);
    chk("ign_a0", addr, 32'h200);
    do_start(32'h0000_0900, 16'd7);
    chk("ign_busy", busy, 1'b1);
    send(7'b0000011, 5'd1, 5'd1, 5'd0, 3'b000, 32'h2);
    chk("ign_a1", addr, 32'h204);
    send(7'b0000011, 5'd1, 5'd1, 5'd0, 3'b000, 32'h3);
    chk("ign_a2", addr, 32'h208);
    chk("ign_done", {we, done}, 2'b11);

    // Reset in the middle of a five-instruction load.
    do_start(32'h0000_0300, 16'd5);
    send(vecs[0].op, vecs[0].rd, vecs[0].rs1, vecs[0].rs2, vecs[0].f3, vecs[0].imm);
    send(vecs[0].op, vecs[0].rd, vecs[0].rs1, vecs[0].rs2, vecs[0].f3, vecs[0].imm);
    chk("mid_a1", addr, 32'h304);
    valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_flags", {we, ready, busy, done, error}, 5'b0);
    chk("mid_rst_addr", addr, 32'h0);
    chk("mid_rst_wdata", wdata, 32'h0);
    chk("mid_rst_idx", err_index, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("mid_no_we", {we, busy}, 2'b00);
    end
    valid = 1'b0;

    // Random legal stream with address wrap, checked by round trip.
    begin
      logic [31:0] exp_addr;
      logic [6:0]  op;
      logic [31:0] im;
      logic [4:0]  s1;
      exp_addr = 32'hFFFF_FF00;
      do_start(32'hFFFF_FF00, 16'd1000);
      for (int k = 0; k < 1000; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          tick();
          chk("rnd_gap", we, 1'b0);
        end
        case ($urandom_range(0, 2))
          0: begin op = 7'b0000011; im = 32'($signed(12'($urandom))); end
          1: begin op = 7'b0100011; im = 32'($signed(12'($urandom))); end
          default: begin op = 7'b1100011; im = 32'($signed(13'($urandom))) & ~32'h1; end
        endcase
        s1 = 5'($urandom);
        send(op, 5'($urandom), s1, 5'($urandom), 3'($urandom), im);
        chk("rnd_we", we, 1'b1);
        chk("rnd_addr", addr, exp_addr);
        chk("rnd_op", wdata[6:0], op);
        chk("rnd_rs1", wdata[19:15], s1);
        chk("rnd_imm", ext_imm(wdata), im);
        exp_addr = exp_addr + 32'd4;
      end
      chk("rnd_done", {done, error, busy}, 3'b100);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imm_encode_loader.md
Name: imm_encode_loader

Overview:
- Inverse of the immediate extender: takes decoded instruction fields (opcode, registers, funct3, 32-bit immediate) and packs them into a 32-bit RV32I word for I, S and B formats.
- Writes each encoded word sequentially into instruction memory, starting at a programmed base address.
- Used by boot/self-test logic to fill instruction memory before the single-cycle core is released.
- Checks that each immediate is representable. An unrepresentable immediate or an unknown opcode stops the load with an error.

Parameters:
- CNT_W, 16, width of the instruction count and index.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous, active-high reset
- i_start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE
- i_baseAddr  input  32  byte address of the first word; must be word aligned, bits [1:0] ignored
- i_count  input  CNT_W  number of instructions to load
- i_valid  input  1  field bundle valid
- o_ready  output  1  block accepts the bundle
- i_opcode  input  7  pa_riscv opcode (I, S or B)
- i_rd  input  5  destination register
- i_rs1  input  5  source register 1
- i_rs2  input  5  source register 2
- i_funct3  input  3  funct3 field
- i_imm  input  32  sign-extended immediate
- o_we  output  1  instruction-memory write strobe
- o_addr  output  32  instruction-memory byte address
- o_wdata  output  32  encoded instruction
- o_busy  output  1  load in progress
- o_done  output  1  load completed without error
- o_error  output  1  load aborted
- o_errIndex  output  CNT_W  index of the offending bundle

Behaviour:
- Reset values: all outputs are 0; state is IDLE; index and address registers are 0.
- Reset asserted mid-load aborts the load immediately. No further writes occur.
- States: IDLE, RUN, DONE, ERR.
  - IDLE/DONE/ERR + i_start: latch base = {i_baseAddr[31:2], 2'b00}, remaining = i_count, index = 0, clear o_done and o_error.
    - If i_count == 0, go to DONE.
    - Otherwise go to RUN.
  - i_start in RUN is ignored.
- RUN:
  - o_ready = 1 and o_busy = 1.
  - A transfer occurs when i_valid && o_ready.
  - o_ready is 0 in every other state.
- Latency: a bundle accepted at cycle N produces o_we = 1 for exactly one cycle at N+1, with o_addr = base + 4*index and o_wdata = the encoded word.
  - Index increments after each write.
  - Memory never back-pressures.
- Encoding (op = i_opcode):
  - I: {imm[11:0], rs1, funct3, rd, op}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}
- Legality:
  - I/S: imm[31:11] must be all equal.
  - B: imm[31:12] must be all equal, and imm[0] must be 0.
  - Any other opcode is illegal.
- Illegal bundle:
  - No write occurs.
  - Next cycle: state = ERR, o_error = 1 (sticky until i_start or reset), o_errIndex = the current index.
- Last accepted legal bundle (remaining == 1): the write occurs at N+1 and o_done rises in that same cycle. State = DONE; o_done stays 1 until i_start or reset.
- Address wraps modulo 2^32. No other bound checks are made.
- Round-trip invariant: for every legal bundle, extending o_wdata with the extender reproduces i_imm exactly (for B, with bit 0 = 0).

Decomposition:
- pa_riscv holds the opcode enum (I, S, B) already shared with the decoder side.
- Add to pa_riscv: the state typedef (IDLE, RUN, DONE, ERR) and the format field-position constants.
- Natural sub-module: imm_pack, purely combinational. It takes opcode, registers, funct3 and imm, and returns the packed word plus a legal flag. It is reusable by an assembler-side test model.
- The top holds the FSM, counters and output register.

Test Plan:
- Start with base 0x100 and count 1, then send I (op 0000011), rd=5, rs1=2, funct3=010, imm=0xFFFFFFFC. Expect a one-cycle write, addr 0x100, wdata 0xFFC12283, o_done=1.
- Send S (op 0100011), rs1=2, rs2=6, funct3=010, imm=8, then B (op 1100011), rs1=rs2=4, funct3=000, imm=0xFFFFFFF8, with count 2. Expect writes 0x00612423 @0x100 and 0xFE420CE3 @0x104, then done.
- I with imm=0x800, as the third bundle of count 4. Expect no third write, o_error=1, o_errIndex=2, o_ready=0 afterwards.
- B with imm=5. Expect an error with no write. An unknown opcode 0110011 also gives an error.
- Start with count 0. Expect o_done=1 the next cycle with no writes. i_start during RUN is ignored and addresses continue.
- i_rst after 2 of 5 writes. Expect all outputs 0 next cycle and no further o_we despite i_valid. Also run a 1000-bundle random legal stream, checking the extender round-trip and address increments of 4.
